// File: rtl/scrub_pkg.sv
// Shared types and helpers for the config-RAM scrubber: FSM states, the
// triplicated word layout and the bitwise majority vote.
package scrub_pkg;

  localparam int COPY_W = 4;
  localparam int WORD_W = 3 * COPY_W;
  localparam int C0_LSB = 0;
  localparam int C1_LSB = COPY_W;
  localparam int C2_LSB = 2 * COPY_W;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    U_WR   = 4'd1,
    U_RD   = 4'd2,
    U_RDW  = 4'd3,
    ACK    = 4'd4,
    S_RD   = 4'd5,
    S_WAIT = 4'd6,
    S_WB   = 4'd7,
    S_NEXT = 4'd8
  } state_e;

  typedef struct packed {
    logic              mismatch;
    logic [COPY_W-1:0] value;
  } vote_t;

  function automatic logic [WORD_W-1:0] triplicate(input logic [COPY_W-1:0] v);
    return {v, v, v};
  endfunction

  function automatic vote_t vote_word(input logic [WORD_W-1:0] word);
    logic [COPY_W-1:0] c0, c1, c2, v;
    vote_t             res;
    c0 = word[C0_LSB +: COPY_W];
    c1 = word[C1_LSB +: COPY_W];
    c2 = word[C2_LSB +: COPY_W];
    v  = (c0 & c1) | (c1 & c2) | (c0 & c2);
    res.value    = v;
    res.mismatch = (c0 != v) || (c1 != v) || (c2 != v);
    return res;
  endfunction

endpackage

// File: rtl/scrub_ctrl_if.sv
// User-side request/acknowledge bus of the scrub controller.
interface scrub_ctrl_if
  import scrub_pkg::*;
#(
  parameter int ADDR_W = 4
) ();
  logic              user_req;
  logic              user_we;
  logic [ADDR_W-1:0] user_addr;
  logic [COPY_W-1:0] user_wdata;
  logic              user_ack;
  logic [COPY_W-1:0] user_rdata;
  logic              user_err;

  modport master (
    output user_req, user_we, user_addr, user_wdata,
    input  user_ack, user_rdata, user_err
  );

  modport slave (
    input  user_req, user_we, user_addr, user_wdata,
    output user_ack, user_rdata, user_err
  );
endinterface

// File: rtl/scrub_ctrl_tmr_vote.sv
// Combinational majority voter over one triplicated RAM word.
module tmr_vote
  import scrub_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [COPY_W-1:0] value,
  output logic              mismatch
);
  vote_t vote_s;

  assign vote_s   = vote_word(word);
  assign value    = vote_s.value;
  assign mismatch = vote_s.mismatch;
endmodule

// File: rtl/scrub_ctrl.sv
// Sequencer/arbiter for the triplicated config RAM: serves user reads and
// writes and interleaves a background vote-and-correct scrub walk.
module scrub_ctrl
  import scrub_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int NUM_WORDS      = 4,
  parameter int SCRUB_INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  scrub_ctrl_if.slave       user,
  input  logic              scrub_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wr_data,
  output logic              ram_rd_enable,
  output logic              ram_wr_enable,
  input  logic [WORD_W-1:0] ram_rd_data,
  output logic [15:0]       corr_count,
  output logic              pass_done
);
  localparam int                CNT_W      = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SCRUB_INTERVAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_WORDS - 1);

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] scrub_addr_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [WORD_W-1:0] ram_wr_data_r;
  logic              rd_en_r;
  logic              wr_en_r;
  logic              ack_r;
  logic [COPY_W-1:0] rdata_r;
  logic              err_r;
  logic [15:0]       corr_count_r;
  logic              pass_done_r;
  logic              last_user_r;
  logic [COPY_W-1:0] vote_value_s;
  logic              vote_mismatch_s;
  logic              pick_scrub_s;

  tmr_vote u_vote (
    .word     (ram_rd_data),
    .value    (vote_value_s),
    .mismatch (vote_mismatch_s)
  );

  // Scrub wins IDLE when due and either the user just had a turn or is absent.
  always_comb begin
    pick_scrub_s = 1'b0;
    if (scrub_en && (cnt_r == {CNT_W{1'b0}})) begin
      pick_scrub_s = last_user_r || !user.user_req;
    end else begin
      pick_scrub_s = 1'b0;
    end
  end

  // Interval counter: runs down while enabled, parked at reload otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_RELOAD;
    end else if ((state_r == S_NEXT) || !scrub_en) begin
      cnt_r <= CNT_RELOAD;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Main FSM; strobes and RAM address/data are registered on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      scrub_addr_r  <= {ADDR_W{1'b0}};
      ram_addr_r    <= {ADDR_W{1'b0}};
      ram_wr_data_r <= {WORD_W{1'b0}};
      rd_en_r       <= 1'b0;
      wr_en_r       <= 1'b0;
      ack_r         <= 1'b0;
      rdata_r       <= {COPY_W{1'b0}};
      err_r         <= 1'b0;
      corr_count_r  <= 16'h0000;
      pass_done_r   <= 1'b0;
      last_user_r   <= 1'b0;
    end else begin
      ram_addr_r    <= {ADDR_W{1'b0}};
      ram_wr_data_r <= {WORD_W{1'b0}};
      rd_en_r       <= 1'b0;
      wr_en_r       <= 1'b0;
      ack_r         <= 1'b0;
      pass_done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_scrub_s) begin
            state_r     <= S_RD;
            rd_en_r     <= 1'b1;
            ram_addr_r  <= scrub_addr_r;
            last_user_r <= 1'b0;
          end else if (user.user_req) begin
            ram_addr_r <= user.user_addr;
            if (user.user_we) begin
              state_r       <= U_WR;
              wr_en_r       <= 1'b1;
              ram_wr_data_r <= triplicate(user.user_wdata);
            end else begin
              state_r <= U_RD;
              rd_en_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        U_WR: begin
          state_r <= ACK;
          ack_r   <= 1'b1;
        end
        U_RD: begin
          state_r <= U_RDW;
        end
        U_RDW: begin
          rdata_r <= vote_value_s;
          err_r   <= vote_mismatch_s;
          state_r <= ACK;
          ack_r   <= 1'b1;
        end
        ACK: begin
          last_user_r <= 1'b1;
          state_r     <= IDLE;
        end
        S_RD: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (vote_mismatch_s) begin
            state_r       <= S_WB;
            wr_en_r       <= 1'b1;
            ram_addr_r    <= scrub_addr_r;
            ram_wr_data_r <= triplicate(vote_value_s);
          end else begin
            state_r <= S_NEXT;
          end
        end
        S_WB: begin
          if (corr_count_r != 16'hFFFF) begin
            corr_count_r <= corr_count_r + 16'd1;
          end else begin
            corr_count_r <= corr_count_r;
          end
          state_r <= S_NEXT;
        end
        S_NEXT: begin
          if (scrub_addr_r == LAST_ADDR) begin
            scrub_addr_r <= {ADDR_W{1'b0}};
            pass_done_r  <= 1'b1;
          end else begin
            scrub_addr_r <= scrub_addr_r + ADDR_W'(1);
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ram_addr        = ram_addr_r;
  assign ram_wr_data     = ram_wr_data_r;
  assign ram_rd_enable   = rd_en_r;
  assign ram_wr_enable   = wr_en_r;
  assign corr_count      = corr_count_r;
  assign pass_done       = pass_done_r;
  assign user.user_ack   = ack_r;
  assign user.user_rdata = rdata_r;
  assign user.user_err   = err_r;

endmodule

// File: tb/tb_scrub_ctrl.sv
// Directed bench for scrub_ctrl: vector table of user transactions plus
// hand-written scrub pass, contention, saturation and reset sequences.
module tb_scrub_ctrl;
  import scrub_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scrub_en;
  logic [3:0]  ram_addr;
  logic [11:0] ram_wr_data;
  logic        ram_rd_enable;
  logic        ram_wr_enable;
  logic [11:0] ram_rd_data;
  logic [15:0] corr_count;
  logic        pass_done;

  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [11:0] bd_data;
  logic [11:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt = 0;
  int overlap_cnt = 0;
  int pass_cnt = 0;
  logic [3:0]  last_wr_addr = 4'h0;
  logic [11:0] last_wr_data = 12'h000;

  scrub_ctrl_if #(.ADDR_W(4)) uif ();

  scrub_ctrl #(.ADDR_W(4), .NUM_WORDS(4), .SCRUB_INTERVAL(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .user          (uif),
    .scrub_en      (scrub_en),
    .ram_addr      (ram_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_rd_enable (ram_rd_enable),
    .ram_wr_enable (ram_wr_enable),
    .ram_rd_data   (ram_rd_data),
    .corr_count    (corr_count),
    .pass_done     (pass_done)
  );

  always #5 clk = ~clk;

  // Single-port RAM: reads win over writes; backdoor used only while idle.
  always @(posedge clk) begin
    if (ram_rd_enable) ram_rd_data <= mem[ram_addr];
    else if (ram_wr_enable) mem[ram_addr] <= ram_wr_data;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  // Bus monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_rd_enable && ram_wr_enable) overlap_cnt <= overlap_cnt + 1;
    if (ram_wr_enable) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= ram_addr;
      last_wr_data <= ram_wr_data;
    end
    if (pass_done) pass_cnt <= pass_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_user(input logic we, input logic [3:0] addr, input logic [3:0] wdata,
                         output int lat, output int wr_cyc, output int rd_cyc,
                         output logic [11:0] wr_seen, output logic [3:0] rdata, output logic err);
    lat = -1; wr_cyc = -1; rd_cyc = -1; wr_seen = 12'h000; rdata = 4'h0; err = 1'b0;
    @(negedge clk);
    uif.user_we = we; uif.user_addr = addr; uif.user_wdata = wdata; uif.user_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_wr_enable && wr_cyc < 0) begin wr_cyc = k; wr_seen = ram_wr_data; end
      if (ram_rd_enable && rd_cyc < 0) rd_cyc = k;
      if (uif.user_ack) begin lat = k; rdata = uif.user_rdata; err = uif.user_err; break; end
    end
    @(posedge clk); #1;
    uif.user_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [3:0]  wdata;
    logic        pre;
    logic [11:0] pre_word;
    int          exp_lat;
    logic [3:0]  exp_rdata;
    logic        exp_err;
    logic [11:0] exp_word;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, wr_cyc, rd_cyc;
    logic [11:0] wr_seen;
    logic [3:0]  rdata;
    logic        err;
    int wr0, pass0, last_rd, scrubs, acks, viol, last_ack_cyc, last_scrub_cyc;
    logic pend_user, seen, found;
    logic [3:0]  wb_addr;
    logic [11:0] wb_data;

    vecs[0] = '{1'b1, 4'h2, 4'hA, 1'b0, 12'h000, 2, 4'h0, 1'b0, 12'hAAA};
    vecs[1] = '{1'b0, 4'h2, 4'h0, 1'b0, 12'h000, 3, 4'hA, 1'b0, 12'hAAA};
    vecs[2] = '{1'b0, 4'h5, 4'h0, 1'b1, 12'hA5A, 3, 4'hA, 1'b1, 12'hA5A};
    vecs[3] = '{1'b0, 4'h6, 4'h0, 1'b1, 12'h137, 3, 4'h3, 1'b1, 12'h137};
    vecs[4] = '{1'b1, 4'hF, 4'h5, 1'b0, 12'h000, 2, 4'h0, 1'b0, 12'h555};
    vecs[5] = '{1'b0, 4'hF, 4'h0, 1'b0, 12'h000, 3, 4'h5, 1'b0, 12'h555};
    vecs[6] = '{1'b0, 4'h0, 4'h0, 1'b1, 12'hFFE, 3, 4'hF, 1'b1, 12'hFFE};
    vecs[7] = '{1'b1, 4'h7, 4'hC, 1'b1, 12'h123, 2, 4'h0, 1'b0, 12'hCCC};

    rst_n = 1'b0; scrub_en = 1'b0; bd_we = 1'b0; bd_addr = 4'h0; bd_data = 12'h000;
    uif.user_req = 1'b0; uif.user_we = 1'b0; uif.user_addr = 4'h0; uif.user_wdata = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {30'd0, ram_rd_enable, ram_wr_enable}, 32'd0);
    check("rst_addr_data", {16'd0, ram_addr, ram_wr_data}, 32'd0);
    check("rst_user_out", {26'd0, uif.user_ack, uif.user_rdata, uif.user_err}, 32'd0);
    check("rst_corr_count", 32'(corr_count), 32'd0);
    check("rst_pass_done", 32'(pass_done), 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) preload(4'(a), 12'h000);

    // Table of user transactions with the scrubber disabled.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre) preload(vecs[i].addr, vecs[i].pre_word);
      do_user(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, wr_cyc, rd_cyc, wr_seen, rdata, err);
      check($sformatf("v%0d_ack_cycle", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].we) begin
        check($sformatf("v%0d_wr_cycle", i), 32'(wr_cyc), 32'd1);
        check($sformatf("v%0d_wr_data", i), 32'(wr_seen), 32'(vecs[i].exp_word));
      end else begin
        check($sformatf("v%0d_rd_cycle", i), 32'(rd_cyc), 32'd1);
        check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
        check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
        check($sformatf("v%0d_no_write", i), 32'(wr_cyc), 32'hFFFF_FFFF);
      end
      check($sformatf("v%0d_mem", i), 32'(mem[vecs[i].addr]), 32'(vecs[i].exp_word));
    end

    // One full scrub pass over words 0..3 with word 1 corrupted.
    preload(4'h0, 12'h333); preload(4'h1, 12'h0F0); preload(4'h2, 12'hAAA); preload(4'h3, 12'h555);
    @(negedge clk);
    wr0 = wr_cnt; pass0 = pass_cnt; last_rd = -1; found = 1'b0;
    scrub_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ram_rd_enable) last_rd = int'(ram_addr);
      if (pass_done) begin found = 1'b1; break; end
    end
    scrub_en = 1'b0;
    repeat (4) @(negedge clk);
    check("pass_done_seen", 32'(found), 32'd1);
    check("pass_last_addr", 32'(last_rd), 32'd3);
    check("pass_done_count", 32'(pass_cnt - pass0), 32'd1);
    check("pass_write_count", 32'(wr_cnt - wr0), 32'd1);
    check("pass_write_addr", 32'(last_wr_addr), 32'd1);
    check("pass_write_data", 32'(last_wr_data), 32'h000);
    check("pass_mem1", 32'(mem[1]), 32'h000);
    check("pass_corr_count", 32'(corr_count), 32'd1);

    // Continuous user reads against a due scrubber: ACK -> S_RD alternation.
    preload(4'h9, 12'h666);
    @(negedge clk);
    uif.user_we = 1'b0; uif.user_addr = 4'h9; uif.user_req = 1'b1; scrub_en = 1'b1;
    scrubs = 0; acks = 0; viol = 0; last_ack_cyc = -100; last_scrub_cyc = -100; pend_user = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (uif.user_ack) begin
        acks++; last_ack_cyc = c;
        if (uif.user_rdata != 4'h6) viol++;
      end
      if (ram_rd_enable && ram_addr == 4'h9 && pend_user) begin
        if (c != last_scrub_cyc + 4) viol++;
        pend_user = 1'b0;
      end
      if (ram_rd_enable && ram_addr < 4'h4) begin
        scrubs++;
        if (c != last_ack_cyc + 2) viol++;
        last_scrub_cyc = c; pend_user = 1'b1;
      end
    end
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (uif.user_ack) begin found = 1'b1; break; end
    end
    @(posedge clk); #1;
    uif.user_req = 1'b0; scrub_en = 1'b0;
    repeat (12) @(negedge clk);
    check("alt_final_ack", 32'(found), 32'd1);
    check("alt_violations", 32'(viol), 32'd0);
    check("alt_scrub_steps_ge5", 32'(scrubs >= 5), 32'd1);
    check("alt_user_acks_ge20", 32'(acks >= 20), 32'd1);

    // Saturation: counter forced to all-ones, then one more correction.
    force dut.corr_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.corr_count_r;
    for (int a = 0; a < 4; a++) preload(4'(a), 12'h011);
    @(negedge clk);
    scrub_en = 1'b1; seen = 1'b0; wb_data = 12'h000;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (ram_wr_enable) begin seen = 1'b1; wb_data = ram_wr_data; break; end
    end
    repeat (3) @(negedge clk);
    scrub_en = 1'b0;
    repeat (6) @(negedge clk);
    check("sat_write_seen", 32'(seen), 32'd1);
    check("sat_write_data", 32'(wb_data), 32'h111);
    check("sat_corr_count", 32'(corr_count), 32'hFFFF);

    // Reset asserted in the middle of a scrub write-back.
    for (int a = 0; a < 4; a++) preload(4'(a), 12'h011);
    @(negedge clk);
    scrub_en = 1'b1; seen = 1'b0; wb_addr = 4'h0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (ram_wr_enable) begin seen = 1'b1; wb_addr = ram_addr; break; end
    end
    rst_n = 1'b0; scrub_en = 1'b0;
    #1;
    check("rstwb_write_seen", 32'(seen), 32'd1);
    check("rstwb_wr_strobe", 32'(ram_wr_enable), 32'd0);
    check("rstwb_state", 32'(dut.state_r), 32'(IDLE));
    check("rstwb_scrub_addr", 32'(dut.scrub_addr_r), 32'd0);
    check("rstwb_corr_count", 32'(corr_count), 32'd0);
    @(posedge clk); #1;
    check("rstwb_write_dropped", 32'(mem[wb_addr]), 32'h011);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("no_strobe_overlap", 32'(overlap_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
